// File: rtl/parallel_in_ctrl.sv
// Parallel input port: per-channel two-flop synchronizer, capture register and change flag,
// read through a small memory-mapped window. Optional debounce via PARALLEL_IN_DEBOUNCE_EN.
module parallel_in_ctrl #(
   parameter int unsigned      WIDTH      = 8,
   parameter int unsigned      NUM_CH     = 4,
   parameter logic [WIDTH-1:0] BASE_ADDR  = 8'hF0,
   parameter int unsigned      DEB_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] Data_in,
   input  logic [WIDTH-1:0]        Address,
   input  logic                    rd_en,
   input  logic [WIDTH-1:0]        MemData,
   output logic [WIDTH-1:0]        RegData
);

   // The status word sits directly after the last channel; wrap is rejected below.
   localparam logic [WIDTH-1:0] STAT_ADDR = BASE_ADDR + WIDTH'(NUM_CH);

   if (NUM_CH < 1 || NUM_CH > WIDTH) begin : g_bad_num_ch
      $error("parallel_in_ctrl: NUM_CH must be in 1..WIDTH");
   end
   if ((64'(BASE_ADDR) + 64'(NUM_CH)) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_base
      $error("parallel_in_ctrl: BASE_ADDR+NUM_CH wraps the address space");
   end
   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("parallel_in_ctrl: DEB_CYCLES must be at least 1");
   end

   logic [NUM_CH-1:0][WIDTH-1:0] sync1_q;
   logic [NUM_CH-1:0][WIDTH-1:0] sync2_q;
   logic [NUM_CH-1:0][WIDTH-1:0] cap_q;
   logic [NUM_CH-1:0][WIDTH-1:0] cap_d;
   logic [NUM_CH-1:0]            chg_q;
   logic [NUM_CH-1:0]            chg_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cap_q   <= '0;
         chg_q   <= '0;
      end else begin
         sync1_q <= Data_in;
         sync2_q <= sync1_q;
         cap_q   <= cap_d;
         chg_q   <= chg_d;
      end
   end

`ifdef PARALLEL_IN_DEBOUNCE_EN
   localparam int unsigned     CW       = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [NUM_CH-1:0][CW-1:0] cnt_q;
   logic [NUM_CH-1:0][CW-1:0] cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt counts edges on which sync2 held a value different from cap; sync1!=sync2
   // means sync2 is about to change, which restarts the run.
   always_comb begin
      cap_d = cap_q;
      cnt_d = cnt_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sync2_q[k] == cap_q[k]) begin
            cnt_d[k] = '0;
         end else if (cnt_q[k] >= CNT_LAST) begin
            cap_d[k] = sync2_q[k];
            cnt_d[k] = '0;
         end else if (sync1_q[k] != sync2_q[k]) begin
            cnt_d[k] = '0;
         end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
         end
      end
   end
`else
   always_comb begin
      cap_d = sync2_q;
   end
`endif

   // A capture change sets the flag even if a read clears it on the same edge.
   always_comb begin
      chg_d = chg_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cap_d[k] != cap_q[k]) begin
            chg_d[k] = 1'b1;
         end else if (rd_en && (Address == BASE_ADDR + WIDTH'(k) || Address == STAT_ADDR)) begin
            chg_d[k] = 1'b0;
         end
      end
   end

   always_comb begin
      RegData = MemData;
      if (Address == STAT_ADDR) begin
         RegData             = '0;
         RegData[NUM_CH-1:0] = chg_q;
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (Address == BASE_ADDR + WIDTH'(k)) begin
            RegData = cap_q[k];
         end
      end
   end

endmodule

// File: tb/tb_parallel_in_ctrl.sv
// Directed and randomized bench for parallel_in_ctrl against a delay-line/history reference model.
module tb_parallel_in_ctrl;

   localparam int         W    = 8;
   localparam int         N    = 4;
   localparam logic [7:0] BASE = 8'hF0;
   localparam int         DEB  = 4;
   localparam int         HD   = 16;
`ifdef PARALLEL_IN_DEBOUNCE_EN
   localparam int LAT = DEB + 2;
`else
   localparam int LAT = 3;
`endif

   logic           clk     = 1'b0;
   logic           rst_n   = 1'b1;
   logic [N*W-1:0] Data_in = '0;
   logic [W-1:0]   Address = '0;
   logic           rd_en   = 1'b0;
   logic [W-1:0]   MemData = '0;
   logic [W-1:0]   RegData;

   int n_tests = 0;
   int n_fail  = 0;

   logic [N*W-1:0] hist [$];
   logic [W-1:0]   cap_m [N];
   logic [N-1:0]   chg_m;

   always #5 clk = ~clk;

   parallel_in_ctrl #(
      .WIDTH(W), .NUM_CH(N), .BASE_ADDR(BASE), .DEB_CYCLES(DEB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .Data_in(Data_in), .Address(Address),
      .rd_en(rd_en), .MemData(MemData), .RegData(RegData)
   );

   function automatic logic [N*W-1:0] pk(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                         input logic [W-1:0] c2, input logic [W-1:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   function automatic logic [W-1:0] chan(input logic [N*W-1:0] v, input int k);
      return v[k*W +: W];
   endfunction

   task automatic model_reset();
      hist = {};
      for (int i = 0; i < HD; i++) hist.push_back('0);
      for (int k = 0; k < N; k++) cap_m[k] = '0;
      chg_m = '0;
   endtask

   // hist[j] = Data_in seen j edges ago; the capture register follows the value
   // that entered two edges before (plus a stability window when debouncing).
   task automatic model_edge();
      logic [W-1:0] nxt;
      logic [W-1:0] cand;
      bit           stable;
      bit           clr;
      hist.push_front(Data_in);
      hist.delete(HD);
      for (int k = 0; k < N; k++) begin
         cand = chan(hist[2], k);
`ifdef PARALLEL_IN_DEBOUNCE_EN
         stable = 1'b1;
         for (int j = 3; j <= DEB + 1; j++) if (chan(hist[j], k) != cand) stable = 1'b0;
         nxt = stable ? cand : cap_m[k];
`else
         stable = 1'b1;
         nxt = cand;
`endif
         clr = rd_en && (int'(Address) == int'(BASE) + k || int'(Address) == int'(BASE) + N);
         if (nxt != cap_m[k])  chg_m[k] = 1'b1;
         else if (clr)         chg_m[k] = 1'b0;
         cap_m[k] = nxt;
      end
   endtask

   function automatic logic [W-1:0] model_rd(input logic [W-1:0] a, input logic [W-1:0] m);
      if (int'(a) >= int'(BASE) && int'(a) < int'(BASE) + N) return cap_m[int'(a) - int'(BASE)];
      if (int'(a) == int'(BASE) + N) return W'(chg_m);
      return m;
   endfunction

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: RegData=%h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic [N*W-1:0] din, input logic [W-1:0] a, input logic rd,
                        input logic [W-1:0] m, input string tag);
      Data_in = din; Address = a; rd_en = rd; MemData = m;
      @(negedge clk);
      check_eq(tag, RegData, model_rd(a, m));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic peek(input logic [W-1:0] a, input logic [W-1:0] m, input string tag,
                       input logic [W-1:0] exp);
      Address = a; MemData = m; rd_en = 1'b0;
      #1;
      check_eq(tag, RegData, exp);
   endtask

   initial begin
      logic [N*W-1:0] d;
      logic [N*W-1:0] d2;
      logic [N*W-1:0] d3;
      logic [W-1:0]   a;
      int             r;

      model_reset();
      #1 rst_n = 1'b0;
      peek(8'hF0, 8'h00, "rst_cap0", 8'h00);
      peek(8'hF4, 8'h00, "rst_status", 8'h00);
      peek(8'h10, 8'h55, "rst_unmapped", 8'h55);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();

      d = pk(8'hAA, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) cycle(d, 8'hF0, 1'b0, 8'h00, "req023_lat");
`ifndef PARALLEL_IN_DEBOUNCE_EN
      peek(8'hF0, 8'h00, "req023_cap", 8'hAA);
      peek(8'hF4, 8'h00, "req023_status", 8'h01);
`endif
      for (int i = 0; i < 6; i++) cycle(d, 8'hF4, 1'b0, 8'h00, "settle_aa");

      cycle(d, 8'h10, 1'b0, 8'h55, "req024_rd0");
      cycle(d, 8'h10, 1'b1, 8'h55, "req024_rd1");
      cycle(d, 8'h10, 1'b1, 8'h55, "req024_rd1b");
      peek(8'h10, 8'h55, "req024_fwd", 8'h55);
      peek(8'hF4, 8'h00, "req024_status", 8'h01);

      cycle(d, 8'hF4, 1'b1, 8'h00, "clr_all");
      d2 = pk(8'h11, 8'h22, 8'h00, 8'h00);
      for (int i = 0; i < 8; i++) cycle(d2, 8'h10, 1'b0, 8'h00, "req025_fill");
      peek(8'hF4, 8'h00, "req025_status3", 8'h03);
      cycle(d2, 8'hF1, 1'b1, 8'h00, "req025_clr1");
      peek(8'hF4, 8'h00, "req025_status1", 8'h01);
      cycle(d2, 8'hF4, 1'b1, 8'h00, "req025_clrall");
      peek(8'hF4, 8'h00, "req025_status0", 8'h00);

      d3 = pk(8'h11, 8'h22, 8'h77, 8'h00);
      for (int i = 0; i < LAT; i++) cycle(d3, 8'hF2, (i == LAT - 1), 8'h00, "req026_seq");
      peek(8'hF2, 8'h00, "req026_cap2", 8'h77);
      peek(8'hF4, 8'h00, "req026_setwins", 8'h04);
      cycle(d3, 8'hF4, 1'b1, 8'h00, "clr_all2");

`ifdef PARALLEL_IN_DEBOUNCE_EN
      for (int i = 0; i < 2; i++) cycle(pk(8'h5A, 8'h22, 8'h77, 8'h00), 8'hF0, 1'b0, 8'h00, "req027_glitch");
      for (int i = 0; i < 8; i++) cycle(d3, 8'hF0, 1'b0, 8'h00, "req027_after");
      peek(8'hF0, 8'h00, "req027_nocap", 8'h11);
      peek(8'hF4, 8'h00, "req027_noflag", 8'h00);
      for (int i = 0; i < DEB + 2; i++) cycle(pk(8'h3C, 8'h22, 8'h77, 8'h00), 8'hF0, 1'b0, 8'h00, "req027_settle");
      peek(8'hF0, 8'h00, "req027_cap", 8'h3C);
`endif

      d = pk(8'hC3, 8'h22, 8'h77, 8'h00);
      for (int i = 0; i < 3; i++) cycle(d, 8'hF0, 1'b0, 8'h00, "req028_pending");
      #2 rst_n = 1'b0;
      model_reset();
      peek(8'hF0, 8'h00, "req028_cap0", 8'h00);
      peek(8'hF2, 8'h00, "req028_cap2", 8'h00);
      peek(8'hF4, 8'h00, "req028_status", 8'h00);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < LAT + 2; i++) cycle(d, 8'hF0, 1'b0, 8'h00, "req028_restart");

      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) d[k*W +: W] = W'($urandom);
         end
         r = $urandom_range(0, 7);
         if (r <= N)      a = BASE + W'(r);
         else if (r == 5) a = 8'h10;
         else             a = W'($urandom);
         cycle(d, a, 1'($urandom_range(0, 1)), W'($urandom), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/parallel_in_ctrl.md
PARALLEL_IN_CTRL -- requirements
Module: parallel_in_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data and address width in bits.
REQ-002 Parameter NUM_CH, default 4: number of input channels; legal range 1..WIDTH.
REQ-003 Parameter BASE_ADDR, default 8'hF0: address of channel 0; channel k at BASE_ADDR+k; status register at BASE_ADDR+NUM_CH.
REQ-004 Parameter DEB_CYCLES, default 4: debounce stability length in cycles (used only under REQ-021).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 Data_in  input  NUM_CH*WIDTH  asynchronous external inputs; channel k at bits [k*WIDTH +: WIDTH].
REQ-008 Address  input  WIDTH  CPU load address.
REQ-009 rd_en  input  1  load strobe; qualifies flag clearing only.
REQ-010 MemData  input  WIDTH  data-memory read data, forwarded when Address is unmapped.
REQ-011 RegData  output  WIDTH  load data returned to the register file.

Function
REQ-012 Each channel SHALL pass through a two-flop synchronizer (sync1, sync2) and then a capture register cap[k].
REQ-013 Without REQ-021, cap[k] SHALL load sync2[k] every cycle; Data_in change before edge N appears in cap at edge N+2 (three edges total).
REQ-014 Change flag chg[k] SHALL set on the edge where cap[k] loads a value different from its current value.
REQ-015 RegData SHALL be combinational: cap[k] when Address==BASE_ADDR+k; {zero-extend, chg[NUM_CH-1:0]} when Address==BASE_ADDR+NUM_CH; MemData otherwise.
REQ-016 Edge with rd_en=1 and Address==BASE_ADDR+k SHALL clear chg[k]; rd_en=1 at the status address SHALL clear all flags.
REQ-017 Set and clear of the same chg[k] on the same edge: set SHALL win.
REQ-018 rd_en=0 SHALL never modify any flag; RegData SHALL be valid regardless of rd_en.
REQ-019 Address arithmetic BASE_ADDR+NUM_CH SHALL be computed in WIDTH bits; configurations where it wraps past 2**WIDTH-1 are illegal (elaboration-time check).

Reset
REQ-020 rst_n low SHALL immediately clear sync1, sync2, cap, chg and all debounce counters to zero; RegData then equals MemData for unmapped addresses and 0 for mapped ones; reset mid-debounce discards the pending value.

Configuration
REQ-021 Macro PARALLEL_IN_DEBOUNCE_EN defined: per-channel counter; cap[k] loads sync2[k] only after sync2[k] differs from cap[k] and holds the same value for DEB_CYCLES consecutive edges; counter clears when sync2[k]==cap[k] or sync2[k] changes; counter saturates, no wrap.
REQ-022 Macro undefined: no counters synthesized; REQ-013 timing applies.

Verification
REQ-023 Reset, Data_in ch0=8'hAA, Address=8'hF0 -> RegData 8'h00 for 2 edges, 8'hAA after 3rd edge; status read (8'hF4) returns 8'h01.
REQ-024 Address=8'h10, MemData=8'h55 -> RegData=8'h55 with no flag change for any rd_en.
REQ-025 chg=4'b0011, rd_en=1, Address=8'hF1 -> after edge status reads 8'h01; rd_en=1 at 8'hF4 -> status 8'h00.
REQ-026 ch2 changes so cap updates on the same edge rd_en=1 clears ch2 -> chg[2] remains 1.
REQ-027 PARALLEL_IN_DEBOUNCE_EN, DEB_CYCLES=4: ch0 glitch of 2 cycles -> cap unchanged, no flag; stable 8'h3C -> cap=8'h3C exactly 4 edges after sync2 settles.
REQ-028 rst_n asserted asynchronously mid-debounce with cap=8'h3C -> cap and flags 0 without a clock edge; counter restarts from 0.
